// File: rtl/xc_pkg.sv
// Shared sizing helpers and FSM encodings for the XC lag correlator.
// Latency: none (compile-time functions and types only).
// Backpressure: not applicable.
package xc_pkg;

    // Ceiling log2, never less than 1 so it can size a vector.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

    // Number of unordered channel pairs (a<b) when cross-correlation is built.
    function automatic int NUM_BASELINES(input int n, input int has_cross);
        return (has_cross != 0) ? (n * (n - 1)) / 2 : 0;
    endfunction

    // Cross lags run from -(lag-1) to +(lag-1).
    function automatic int CROSS_LAGS(input int lag);
        return 2 * lag - 1;
    endfunction

    // Total result words per snapshot: counts, autos, then cross bins.
    function automatic int WORDS(input int n, input int lag, input int has_cross);
        return n + n * lag + NUM_BASELINES(n, has_cross) * CROSS_LAGS(lag);
    endfunction

    // Position of baseline (a,b), a<b, in the order (0,1),(0,2)..(n-2,n-1).
    function automatic int idx(input int a, input int b, input int n);
        return a * n - (a * (a + 1)) / 2 + (b - a - 1);
    endfunction

    typedef enum logic {
        INT_IDLE      = 1'b0,
        INT_INTEGRATE = 1'b1
    } int_state_t;

    typedef enum logic {
        OUT_EMPTY  = 1'b0,
        OUT_STREAM = 1'b1
    } out_state_t;

endpackage

// File: rtl/xc_sat_counter.sv
// Saturating accumulator bin with increment enable and synchronous clear.
// Latency: o_next is combinational; the register takes it on the next edge.
// Backpressure: none; holds at all-ones instead of wrapping.
module xc_sat_counter
    import xc_pkg::*;
#(
    parameter int RESOLUTION = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clr,
    input  logic                  i_inc,
    output logic [RESOLUTION-1:0] o_next
);

    localparam logic [RESOLUTION-1:0] MAX_VAL = '1;

    logic [RESOLUTION-1:0] r_acc;

    // o_next is the value including this cycle's increment, so a snapshot
    // taken on the same edge as the clear still sees the final sample.
    assign o_next = (i_inc && (r_acc != MAX_VAL)) ? r_acc + RESOLUTION'(1) : r_acc;

    // Accumulator register: clear wins over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_next;
        end
    end

endmodule

// File: rtl/xc_lag_correlator.sv
// Lag correlator: per-channel counts, auto and baseline cross spectra over a window.
// Latency: out_valid rises the cycle after the terminal window cycle, word 0 first.
// Backpressure: out_data/out_valid hold while out_ready=0; a window ending mid-stream is dropped and flags overrun.
module xc_lag_correlator
    import xc_pkg::*;
#(
    parameter  int NUM_INPUTS = 2,
    parameter  int LAG        = 4,
    parameter  int DELAY_SIZE = 8,
    parameter  int RESOLUTION = 12,
    parameter  int HAS_CROSS  = 1,
    parameter  int INT_WIDTH  = 24,
    localparam int DW         = clog2(DELAY_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [NUM_INPUTS-1:0]    sample_in,
    input  logic [NUM_INPUTS*DW-1:0] delay_cfg,
    input  logic [INT_WIDTH-1:0]     int_len,
    input  logic                     start,
    input  logic                     stop,
    output logic [RESOLUTION-1:0]    out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CL         = CROSS_LAGS(LAG);
    localparam int W          = WORDS(NUM_INPUTS, LAG, HAS_CROSS);
    localparam int PW         = clog2(W);
    // Registered history excludes the live sample and the never-read top tap.
    localparam int HL         = DELAY_SIZE + LAG - 2;
    localparam int AUTO_BASE  = NUM_INPUTS;
    localparam int CROSS_BASE = NUM_INPUTS + NUM_INPUTS * LAG;

    localparam logic [PW-1:0]        LAST_PTR = PW'(W - 1);
    localparam logic [INT_WIDTH-1:0] WIN_ONE  = INT_WIDTH'(1);

    int_state_t r_int_state, w_int_next;
    out_state_t r_out_state, w_out_next;

    logic [INT_WIDTH-1:0]  r_win;
    logic [INT_WIDTH-1:0]  r_len;
    logic [DW-1:0]         r_delay [NUM_INPUTS];
    logic [HL-1:0]         r_hist  [NUM_INPUTS];
    logic [HL:0]           w_h     [NUM_INPUTS];
    logic [LAG-1:0]        w_dly   [NUM_INPUTS];
    logic [W-1:0]          w_inc;
    logic [RESOLUTION-1:0] w_next  [W];
    logic [RESOLUTION-1:0] r_snap  [W];
    logic [PW-1:0]         r_ptr;
    logic                  r_overrun;

    logic w_acc_en, w_term, w_clr;
    logic w_accept, w_last_acc, w_load, w_ovr_set;

    function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] d);
        if (int'(d) > DELAY_SIZE - 1) begin
            return DW'(DELAY_SIZE - 1);
        end
        return d;
    endfunction

    // A sample counts only when integrating, qualified, and not pre-empted by start/stop.
    assign w_acc_en = (r_int_state == INT_INTEGRATE) && enable && !start && !stop;
    assign w_term   = w_acc_en && (r_win == r_len);
    assign w_clr    = start || w_term;

    // Integration FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_int_state <= INT_IDLE;
        end else begin
            r_int_state <= w_int_next;
        end
    end

    // Integration FSM next state: start (re)enters INTEGRATE, stop leaves it.
    always_comb begin
        w_int_next = r_int_state;
        case (r_int_state)
            INT_IDLE: begin
                if (start) begin
                    w_int_next = INT_INTEGRATE;
                end
            end
            INT_INTEGRATE: begin
                if (!start && stop) begin
                    w_int_next = INT_IDLE;
                end
            end
            default: w_int_next = INT_IDLE;
        endcase
    end

    // Window counter, latched configuration and history shift registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_win <= '0;
            r_len <= '0;
            for (int n = 0; n < NUM_INPUTS; n++) begin
                r_delay[n] <= '0;
                r_hist[n]  <= '0;
            end
        end else if (start) begin
            r_win <= WIN_ONE;
            r_len <= (int_len == '0) ? WIN_ONE : int_len;
            for (int n = 0; n < NUM_INPUTS; n++) begin
                r_delay[n] <= clamp_delay(delay_cfg[n*DW +: DW]);
                r_hist[n]  <= '0;
            end
        end else if (w_acc_en) begin
            r_win <= w_term ? WIN_ONE : r_win + WIN_ONE;
            for (int n = 0; n < NUM_INPUTS; n++) begin
                r_hist[n] <= w_h[n][HL-1:0];
            end
        end
    end

    // Per-channel taps: w_h[n][j] is the sample j enabled cycles ago, and
    // w_dly[n][i] the same history viewed through the channel delay.
    for (genvar n = 0; n < NUM_INPUTS; n++) begin : g_chan
        assign w_h[n]   = {r_hist[n], sample_in[n]};
        assign w_dly[n] = LAG'(w_h[n] >> r_delay[n]);
        assign w_inc[n] = sample_in[n];
        for (genvar l = 0; l < LAG; l++) begin : g_auto
            assign w_inc[AUTO_BASE + n*LAG + l] = w_dly[n][0] & w_dly[n][l];
        end
    end

    // Cross bins: negative lag delays channel a, positive lag delays channel b.
    if (HAS_CROSS != 0) begin : g_cross
        for (genvar a = 0; a < NUM_INPUTS; a++) begin : g_a
            for (genvar b = a + 1; b < NUM_INPUTS; b++) begin : g_b
                for (genvar ki = 0; ki < CL; ki++) begin : g_k
                    localparam int K  = ki - (LAG - 1);
                    localparam int IA = (K < 0) ? -K : 0;
                    localparam int IB = (K > 0) ? K : 0;
                    localparam int WI = CROSS_BASE + idx(a, b, NUM_INPUTS) * CL + ki;
                    assign w_inc[WI] = w_dly[a][IA] & w_dly[b][IB];
                end
            end
        end
    end

    // One accumulator per result word, in output order.
    for (genvar i = 0; i < W; i++) begin : g_bin
        xc_sat_counter #(
            .RESOLUTION (RESOLUTION)
        ) u_bin (
            .i_clk   (clk),
            .i_rst_n (reset_n),
            .i_clr   (w_clr),
            .i_inc   (w_acc_en & w_inc[i]),
            .o_next  (w_next[i])
        );
    end

    assign w_accept   = (r_out_state == OUT_STREAM) && out_ready;
    assign w_last_acc = w_accept && (r_ptr == LAST_PTR);

    // Output FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_state <= OUT_EMPTY;
        end else begin
            r_out_state <= w_out_next;
        end
    end

    // Output FSM next state: load on terminal when free, otherwise flag the drop.
    always_comb begin
        w_out_next = r_out_state;
        w_load     = 1'b0;
        w_ovr_set  = 1'b0;
        case (r_out_state)
            OUT_EMPTY: begin
                if (w_term) begin
                    w_load     = 1'b1;
                    w_out_next = OUT_STREAM;
                end
            end
            OUT_STREAM: begin
                if (w_last_acc) begin
                    if (w_term) begin
                        w_load = 1'b1;
                    end else begin
                        w_out_next = OUT_EMPTY;
                    end
                end else if (w_term) begin
                    w_ovr_set = 1'b1;
                end
            end
            default: w_out_next = OUT_EMPTY;
        endcase
    end

    // Snapshot buffer and read pointer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= '0;
            for (int i = 0; i < W; i++) begin
                r_snap[i] <= '0;
            end
        end else if (w_load) begin
            r_ptr <= '0;
            for (int i = 0; i < W; i++) begin
                r_snap[i] <= w_next[i];
            end
        end else if (w_last_acc) begin
            r_ptr <= '0;
        end else if (w_accept) begin
            r_ptr <= r_ptr + PW'(1);
        end
    end

    // Sticky overrun, cleared by a restart.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_overrun <= 1'b0;
        end else if (start) begin
            r_overrun <= 1'b0;
        end else if (w_ovr_set) begin
            r_overrun <= 1'b1;
        end
    end

    assign out_valid = (r_out_state == OUT_STREAM);
    assign out_last  = out_valid && (r_ptr == LAST_PTR);
    assign out_data  = r_snap[r_ptr];
    assign busy      = (r_int_state != INT_IDLE);
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_xc_lag_correlator.sv
// Directed bench for xc_lag_correlator: two instances (12-bit and 4-bit words).
// Latency: checks sampled 1ns after each rising edge.
// Backpressure: out_ready driven directly by the stimulus sequence.
module tb_xc_lag_correlator;
    import xc_pkg::*;

    localparam int N   = 2;
    localparam int LG  = 4;
    localparam int NW  = 17;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  sample_in = 2'b00;
    logic [5:0]  delay_cfg = 6'd0;
    logic [23:0] int_len = 24'd0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        out_ready = 1'b0;

    logic [11:0] a_data;
    logic        a_valid, a_last, a_busy, a_ovr;
    logic [3:0]  b_data;
    logic        b_valid, b_last, b_busy, b_ovr;

    int errors = 0;
    int checks = 0;
    int exp_a [NW];
    int exp_b [NW];

    always #5 clk = ~clk;

    xc_lag_correlator #(
        .NUM_INPUTS(N), .LAG(LG), .DELAY_SIZE(8), .RESOLUTION(12), .HAS_CROSS(1), .INT_WIDTH(24)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
        .delay_cfg(delay_cfg), .int_len(int_len), .start(start), .stop(stop),
        .out_data(a_data), .out_valid(a_valid), .out_ready(out_ready), .out_last(a_last),
        .busy(a_busy), .overrun(a_ovr)
    );

    xc_lag_correlator #(
        .NUM_INPUTS(N), .LAG(LG), .DELAY_SIZE(8), .RESOLUTION(4), .HAS_CROSS(1), .INT_WIDTH(24)
    ) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .sample_in(sample_in),
        .delay_cfg(delay_cfg), .int_len(int_len), .start(start), .stop(stop),
        .out_data(b_data), .out_valid(b_valid), .out_ready(out_ready), .out_last(b_last),
        .busy(b_busy), .overrun(b_ovr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        sample_in = 2'b00;
        delay_cfg = 6'd0;
        int_len   = 24'd0;
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic start_win(input int len, input logic [5:0] dly);
        int_len   = 24'(len);
        delay_cfg = dly;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic stop_pulse();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    // Expected word for a window of all-ones inputs on both channels, zero delay.
    function automatic int ones_word(input int i, input int len, input int maxv);
        int v;
        int k;
        if (i < N) begin
            v = len;
        end else if (i < N + N * LG) begin
            v = len - ((i - N) % LG);
        end else begin
            k = i - (N + N * LG) - (LG - 1);
            v = len - ((k < 0) ? -k : k);
        end
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic fill_ones(input int len);
        for (int i = 0; i < NW; i++) begin
            exp_a[i] = ones_word(i, len, 4095);
            exp_b[i] = ones_word(i, len, 15);
        end
    endtask

    task automatic fill_zero();
        for (int i = 0; i < NW; i++) begin
            exp_a[i] = 0;
            exp_b[i] = 0;
        end
    endtask

    task automatic drain(input string tag, input bit chk_b);
        out_ready = 1'b1;
        for (int i = 0; i < NW; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), 32'(a_valid), 32'd1);
            chk($sformatf("%s_word%0d", tag, i), 32'(a_data), 32'(exp_a[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(a_last), 32'(i == NW - 1));
            if (chk_b) begin
                chk($sformatf("%s_r4word%0d", tag, i), 32'(b_data), 32'(exp_b[i]));
            end
            tick();
        end
        out_ready = 1'b0;
        chk($sformatf("%s_empty", tag), 32'(a_valid), 32'd0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_overrun", 32'(a_ovr), 32'd0);
        chk("rst_data", 32'(a_data), 32'd0);
        chk("rst_last", 32'(a_last), 32'd0);
        chk("rst_r4valid", 32'(b_valid), 32'd0);

        // Full-ones window, int_len=10
        enable    = 1'b1;
        sample_in = 2'b11;
        start_win(10, 6'd0);
        chk("s1_busy", 32'(a_busy), 32'd1);
        repeat (9) tick();
        chk("s1_not_yet", 32'(a_valid), 32'd0);
        tick();
        chk("s1_valid", 32'(a_valid), 32'd1);
        chk("s1_word0", 32'(a_data), 32'd10);
        stop_pulse();
        chk("s1_idle", 32'(a_busy), 32'd0);
        chk("s1_overrun", 32'(a_ovr), 32'd0);
        fill_ones(10);
        drain("s1", 1'b0);

        // Single pulses: ch0 at cycle 5, ch1 at cycle 7, no delay -> cross[-2]
        sample_in = 2'b00;
        start_win(10, 6'd0);
        for (int c = 1; c <= 10; c++) begin
            sample_in[0] = (c == 5);
            sample_in[1] = (c == 7);
            tick();
        end
        sample_in = 2'b00;
        chk("s2a_valid", 32'(a_valid), 32'd1);
        stop_pulse();
        fill_zero();
        exp_a[0] = 1; exp_a[1] = 1; exp_a[2] = 1; exp_a[6] = 1; exp_a[11] = 1;
        drain("s2a", 1'b0);

        // Same pulses with ch0 delayed by 2 -> cross[0]
        start_win(10, 6'b000_010);
        for (int c = 1; c <= 10; c++) begin
            sample_in[0] = (c == 5);
            sample_in[1] = (c == 7);
            tick();
        end
        sample_in = 2'b00;
        stop_pulse();
        fill_zero();
        exp_a[0] = 1; exp_a[1] = 1; exp_a[2] = 1; exp_a[6] = 1; exp_a[13] = 1;
        drain("s2b", 1'b0);

        // Saturation on the 4-bit instance, int_len=20
        do_reset();
        enable    = 1'b1;
        sample_in = 2'b11;
        start_win(20, 6'd0);
        repeat (19) tick();
        chk("s3_not_yet", 32'(b_valid), 32'd0);
        tick();
        chk("s3_valid", 32'(b_valid), 32'd1);
        chk("s3_word0", 32'(b_data), 32'd15);
        stop_pulse();
        fill_ones(20);
        drain("s3", 1'b1);

        // Backpressure across two terminals -> overrun, first snapshot held
        do_reset();
        enable    = 1'b1;
        sample_in = 2'b11;
        start_win(5, 6'd0);
        repeat (5) tick();
        chk("s4_valid", 32'(a_valid), 32'd1);
        chk("s4_word0", 32'(a_data), 32'd5);
        chk("s4_no_ovr", 32'(a_ovr), 32'd0);
        repeat (5) tick();
        chk("s4_overrun", 32'(a_ovr), 32'd1);
        chk("s4_hold_data", 32'(a_data), 32'd5);
        chk("s4_hold_valid", 32'(a_valid), 32'd1);
        tick();
        chk("s4_hold_data2", 32'(a_data), 32'd5);
        start_win(5, 6'd0);
        chk("s4_ovr_cleared", 32'(a_ovr), 32'd0);
        chk("s4_still_valid", 32'(a_valid), 32'd1);
        stop_pulse();
        fill_ones(5);
        drain("s4", 1'b0);

        // Enable toggling: enabled on even cycles only, int_len=6
        do_reset();
        enable    = 1'b1;
        sample_in = 2'b11;
        start_win(6, 6'd0);
        for (int c = 1; c <= 12; c++) begin
            enable    = (c % 2 == 0);
            sample_in = enable ? 2'b11 : 2'b00;
            tick();
            if (c == 11) begin
                chk("s5_not_yet", 32'(a_valid), 32'd0);
            end
        end
        chk("s5_valid", 32'(a_valid), 32'd1);
        chk("s5_word0", 32'(a_data), 32'd6);
        enable    = 1'b1;
        sample_in = 2'b00;
        stop_pulse();
        fill_ones(6);
        drain("s5", 1'b0);

        // Reset asserted while word 3 is presented
        do_reset();
        enable    = 1'b1;
        sample_in = 2'b11;
        start_win(10, 6'd0);
        repeat (10) tick();
        chk("s6_valid", 32'(a_valid), 32'd1);
        out_ready = 1'b1;
        repeat (3) tick();
        fill_ones(10);
        chk("s6_word3", 32'(a_data), 32'(exp_a[3]));
        reset_n = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(a_valid), 32'd0);
        chk("s6_rst_busy", 32'(a_busy), 32'd0);
        chk("s6_rst_data", 32'(a_data), 32'd0);
        out_ready = 1'b0;
        tick();
        reset_n = 1'b1;
        start_win(10, 6'd0);
        repeat (10) tick();
        stop_pulse();
        drain("s6", 1'b0);

        // Terminal coincides with acceptance of the last word, int_len=17
        do_reset();
        enable    = 1'b1;
        sample_in = 2'b11;
        start_win(17, 6'd0);
        out_ready = 1'b1;
        repeat (17) tick();
        chk("s7_valid", 32'(a_valid), 32'd1);
        chk("s7_word0", 32'(a_data), 32'd17);
        repeat (16) tick();
        chk("s7_last", 32'(a_last), 32'd1);
        tick();
        chk("s7_reload_valid", 32'(a_valid), 32'd1);
        chk("s7_reload_ovr", 32'(a_ovr), 32'd0);
        chk("s7_reload_word0", 32'(a_data), 32'd17);
        chk("s7_reload_last", 32'(a_last), 32'd0);
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
